// File: rtl/smg_scan_sched.sv
// Scan scheduler for a 4-digit 7-segment display: time-multiplexes the shared
// segment bus across four digits with a blank gap at the start of each slot,
// and swaps in new BCD values atomically at frame boundaries.
module smg_scan_sched #(
  parameter int unsigned CLK_FRE   = 27_000_000,
  parameter int unsigned SCAN_HZ   = 1000,
  parameter int unsigned BLANK_CYC = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_vld,
  output logic        upd_rdy,
  input  logic [15:0] upd_bcd,
  input  logic [3:0]  upd_dp,
  input  logic        lz_en,
  output logic [3:0]  dig,
  output logic [7:0]  smg,
  output logic        frame_done
);

  localparam int unsigned DIV = CLK_FRE / SCAN_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    slot, slot_nxt;
  logic          fd_nxt;
  logic          pending, pending_nxt;
  logic [15:0]   pend_bcd, disp_bcd;
  logic [3:0]    pend_dp, disp_dp;
  logic          accept, xfer;
  logic [3:0]    dig_nxt;
  logic [7:0]    smg_nxt;
  logic [3:0]    cur_digit;
  logic          cur_dp, cur_blank;

  // Active-low segment pattern {dp,g,f,e,d,c,b,a}; non-decimal codes show a dash
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hBF;
    endcase
  endfunction

  // Slot digit/dp select and leading-zero blanking (dash codes count as non-zero)
  always_comb begin
    cur_digit = disp_bcd[3:0];
    cur_dp    = disp_dp[0];
    cur_blank = 1'b0;
    case (slot)
      2'd0: begin
        cur_digit = disp_bcd[15:12];
        cur_dp    = disp_dp[3];
        cur_blank = lz_en && (disp_bcd[15:12] == 4'd0);
      end
      2'd1: begin
        cur_digit = disp_bcd[11:8];
        cur_dp    = disp_dp[2];
        cur_blank = lz_en && (disp_bcd[15:8] == 8'd0);
      end
      2'd2: begin
        cur_digit = disp_bcd[7:4];
        cur_dp    = disp_dp[1];
        cur_blank = lz_en && (disp_bcd[15:4] == 12'd0);
      end
      default: begin
        cur_digit = disp_bcd[3:0];
        cur_dp    = disp_dp[0];
        cur_blank = 1'b0;
      end
    endcase
  end

  // Next-state: slot timing, blank/drive phase, output decode and handshake
  always_comb begin
    cnt_nxt     = cnt;
    slot_nxt    = slot;
    state_nxt   = state;
    fd_nxt      = 1'b0;
    dig_nxt     = 4'hF;
    smg_nxt     = 8'hFF;
    pending_nxt = pending;

    if (cnt == CW'(DIV - 1)) begin
      cnt_nxt  = '0;
      slot_nxt = slot + 2'd1;
    end else begin
      cnt_nxt = cnt + CW'(1);
    end

    state_nxt = (cnt_nxt < CW'(BLANK_CYC)) ? ST_BLANK : ST_DRIVE;
    fd_nxt    = (slot_nxt == 2'd3) && (cnt_nxt == CW'(DIV - 1));

    case (state)
      ST_DRIVE: begin
        dig_nxt = ~(4'b0001 << slot);
        smg_nxt = cur_blank ? 8'hFF : seg7(cur_digit);
        if (cur_dp) smg_nxt[7] = 1'b0;
      end
      default: begin
        dig_nxt = 4'hF;
        smg_nxt = 8'hFF;
      end
    endcase

    if (xfer)        pending_nxt = 1'b0;
    else if (accept) pending_nxt = 1'b1;
  end

  assign accept = upd_vld && upd_rdy;
  assign xfer   = frame_done && pending;

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      slot       <= 2'd0;
      frame_done <= 1'b0;
      dig        <= 4'hF;
      smg        <= 8'hFF;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      slot       <= slot_nxt;
      frame_done <= fd_nxt;
      dig        <= dig_nxt;
      smg        <= smg_nxt;
    end
  end

  // Pending/display value registers; transfer only at a frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= 1'b0;
      upd_rdy  <= 1'b1;
      pend_bcd <= 16'h0000;
      pend_dp  <= 4'h0;
      disp_bcd <= 16'h0000;
      disp_dp  <= 4'h0;
    end else begin
      pending <= pending_nxt;
      upd_rdy <= ~pending_nxt;
      if (accept) begin
        pend_bcd <= upd_bcd;
        pend_dp  <= upd_dp;
      end
      if (xfer) begin
        disp_bcd <= pend_bcd;
        disp_dp  <= pend_dp;
      end
    end
  end

endmodule

// File: tb/tb_smg_scan_sched.sv
// Directed bench for smg_scan_sched with a frame-level scoreboard of expected
// segment codes (DIV=10, BLANK_CYC=2).
module tb_smg_scan_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_vld;
  logic        upd_rdy;
  logic [15:0] upd_bcd;
  logic [3:0]  upd_dp;
  logic        lz_en;
  logic [3:0]  dig;
  logic [7:0]  smg;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  smg_scan_sched #(.CLK_FRE(40), .SCAN_HZ(4), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .upd_vld(upd_vld), .upd_rdy(upd_rdy),
    .upd_bcd(upd_bcd), .upd_dp(upd_dp), .lz_en(lz_en),
    .dig(dig), .smg(smg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stop on the negedge where frame_done is visible (outputs at frame position 38)
  task automatic wait_fd();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_done !== 1'b1 && k < 200);
    chk("fd_wait", {31'b0, frame_done}, 32'd1);
  endtask

  // Leave the bench at the negedge where outputs show frame position 0
  task automatic align();
    wait_fd();
    @(negedge clk);
    @(negedge clk);
  endtask

  // Compare one full frame of dig/smg/frame_done against the next scoreboard entry
  task automatic check_frame(input string tag);
    logic [31:0] e;
    logic [3:0]  one;
    logic [3:0]  ed;
    logic [7:0]  es;
    int s, inner;
    one = 4'b0001;
    n_tests++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 40; i++) begin
      s     = i / 10;
      inner = i % 10;
      ed    = (inner < 2) ? 4'hF : ~(one << s);
      es    = (inner < 2) ? 8'hFF : e[31 - 8*s -: 8];
      chk({tag, "_dig"}, {28'b0, dig}, {28'b0, ed});
      chk({tag, "_smg"}, {24'b0, smg}, {24'b0, es});
      chk({tag, "_fd"}, {31'b0, frame_done}, (i == 38) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
  endtask

  // One-cycle valid pulse once ready; optionally push the frame it should produce
  task automatic send_update(input logic [15:0] bcd, input logic [3:0] dp,
                             input logic push, input logic [31:0] exp);
    int k = 0;
    while (upd_rdy !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("upd_rdy_wait", {31'b0, upd_rdy}, 32'd1);
    upd_vld = 1'b1;
    upd_bcd = bcd;
    upd_dp  = dp;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    upd_vld = 1'b0;
    chk("upd_rdy_low", {31'b0, upd_rdy}, 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    upd_vld = 1'b0;
    upd_bcd = 16'h0000;
    upd_dp  = 4'h0;
    lz_en   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dig", {28'b0, dig}, 32'hF);
    chk("rst_smg", {24'b0, smg}, 32'hFF);
    chk("rst_fd", {31'b0, frame_done}, 32'd0);
    chk("rst_rdy", {31'b0, upd_rdy}, 32'd1);
    rst = 1'b0;

    // 1: default display 0000, no blanking
    exp_q.push_back(32'hC0C0C0C0);
    align();
    check_frame("t1");

    // 2: mid-frame update 1234 with dp on tens; ready held low until after frame_done
    repeat (15) @(negedge clk);
    send_update(16'h1234, 4'b0010, 1'b1, 32'hF9A43099);
    begin
      int k = 0;
      while (frame_done !== 1'b1 && k < 100) begin
        chk("t2_rdy_low", {31'b0, upd_rdy}, 32'd0);
        @(negedge clk);
        k++;
      end
    end
    chk("t2_fd", {31'b0, frame_done}, 32'd1);
    chk("t2_rdy_on_fd", {31'b0, upd_rdy}, 32'd0);
    @(negedge clk);
    chk("t2_rdy_back", {31'b0, upd_rdy}, 32'd1);
    @(negedge clk);
    check_frame("t2");

    // 3: leading-zero blanking, including a blanked digit carrying a dp
    lz_en = 1'b1;
    send_update(16'h0050, 4'b1000, 1'b1, 32'h7FFF92C0);
    align();
    check_frame("t3a");
    send_update(16'h0000, 4'b0000, 1'b1, 32'hFFFFFFC0);
    align();
    check_frame("t3b");

    // 4: accept on the frame_done cycle itself; display changes one frame later
    wait_fd();
    chk("t4_rdy_on_fd", {31'b0, upd_rdy}, 32'd1);
    upd_vld = 1'b1;
    upd_bcd = 16'h9999;
    upd_dp  = 4'h0;
    exp_q.push_back(32'hFFFFFFC0);
    exp_q.push_back(32'h90909090);
    @(negedge clk);
    upd_vld = 1'b0;
    chk("t4_accepted", {31'b0, upd_rdy}, 32'd0);
    @(negedge clk);
    check_frame("t4_old");
    check_frame("t4_new");

    // 5: dash codes count as non-zero for blanking
    send_update(16'hA0F3, 4'b0000, 1'b1, 32'hBFC0BFB0);
    align();
    check_frame("t5");

    // 6: async reset in slot 2 with an update pending
    send_update(16'h5678, 4'b0000, 1'b0, 32'h0);
    repeat (20) @(negedge clk);
    chk("t6_pending", {31'b0, upd_rdy}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_dig", {28'b0, dig}, 32'hF);
    chk("t6_smg", {24'b0, smg}, 32'hFF);
    chk("t6_rdy", {31'b0, upd_rdy}, 32'd1);
    chk("t6_fd", {31'b0, frame_done}, 32'd0);
    lz_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'hC0C0C0C0);
    exp_q.push_back(32'hC0C0C0C0);
    align();
    check_frame("t6a");
    check_frame("t6b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
